// File: rtl/basic_cpu_core.sv
// Multi-cycle accumulator CPU: fetch / decode / indirect / execute sequencing
// with a req/ack SRAM port. Memory-port outputs are decoded from the state
// register, so a zero-wait SRAM can ack in the same cycle a request appears.
module basic_cpu_core #(
    parameter int                DWIDTH   = 16,
    parameter int                AWIDTH   = 12,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_mem_ack,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    output logic [AWIDTH-1:0] o_pc,
    output logic [DWIDTH-1:0] o_ac,
    output logic [DWIDTH-1:0] o_ir,
    output logic              o_e,
    output logic              o_halted,
    output logic              o_instr_done
);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_HALT, S_FETCH, S_DECODE, S_INDIR, S_RD, S_OP, S_WR, S_REG
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] ar;
    logic [DWIDTH-1:0] ac;
    logic [DWIDTH-1:0] dr;
    logic [DWIDTH-1:0] ir;
    logic              e;

    logic              ind;
    logic [2:0]        op;
    logic [DWIDTH:0]   sum;
    logic [DWIDTH-1:0] rr_ac;
    logic              rr_e;
    logic              rr_skip;
    logic              rr_halt;

    assign ind = ir[DWIDTH-1];
    assign op  = ir[DWIDTH-2:DWIDTH-4];
    assign sum = {1'b0, ac} + {1'b0, dr};

    // First execute substep of an opcode (after any indirection).
    function automatic state_t exec_entry(input logic [2:0] opc);
        case (opc)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: exec_entry = S_RD;
            OP_STA, OP_BSA:                 exec_entry = S_WR;
            OP_BUN:                         exec_entry = S_OP;
            default:                        exec_entry = S_REG;
        endcase
    endfunction

    // Register-reference result: only the highest set bit of IR[11:0] acts; I=1 is a NOP.
    always_comb begin
        rr_ac   = ac;
        rr_e    = e;
        rr_skip = 1'b0;
        rr_halt = 1'b0;
        if (!ind) begin
            if (ir[11])     rr_ac = '0;
            else if (ir[10]) rr_e = 1'b0;
            else if (ir[9])  rr_ac = ~ac;
            else if (ir[8])  rr_e = ~e;
            else if (ir[7]) begin
                rr_ac = {e, ac[DWIDTH-1:1]};
                rr_e  = ac[0];
            end else if (ir[6]) begin
                rr_ac = {ac[DWIDTH-2:0], e};
                rr_e  = ac[DWIDTH-1];
            end
            else if (ir[5])  rr_ac = ac + 1'b1;
            else if (ir[4])  rr_skip = ~ac[DWIDTH-1];
            else if (ir[3])  rr_skip = ac[DWIDTH-1];
            else if (ir[2])  rr_skip = (ac == '0);
            else if (ir[1])  rr_skip = ~e;
            else if (ir[0])  rr_halt = 1'b1;
        end
    end

    // Instruction sequencer and architectural registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ar    <= '0;
            ac    <= '0;
            dr    <= '0;
            ir    <= '0;
            e     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (i_start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_mem_ack) begin
                        ir    <= i_mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ar <= ir[AWIDTH-1:0];
                    if (op != OP_REG && ind) state <= S_INDIR;
                    else                     state <= exec_entry(op);
                end
                S_INDIR: begin
                    if (i_mem_ack) begin
                        ar    <= i_mem_rdata[AWIDTH-1:0];
                        state <= exec_entry(op);
                    end
                end
                S_RD: begin
                    if (i_mem_ack) begin
                        dr    <= i_mem_rdata;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    case (op)
                        OP_AND:  ac <= ac & dr;
                        OP_ADD:  {e, ac} <= sum;
                        OP_LDA:  ac <= dr;
                        OP_BUN:  pc <= ar;
                        OP_BSA:  pc <= ar + 1'b1;
                        OP_ISZ:  dr <= dr + 1'b1;
                        default: ;
                    endcase
                    state <= (op == OP_ISZ) ? S_WR : S_FETCH;
                end
                S_WR: begin
                    if (i_mem_ack) begin
                        if (op == OP_BSA) begin
                            state <= S_OP;
                        end else begin
                            if (op == OP_ISZ && dr == '0) pc <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_REG: begin
                    ac <= rr_ac;
                    e  <= rr_e;
                    if (rr_skip) pc <= pc + 1'b1;
                    state <= rr_halt ? S_HALT : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_req    = (state == S_FETCH) || (state == S_INDIR) ||
                          (state == S_RD)    || (state == S_WR);
    assign o_mem_we     = (state == S_WR);
    assign o_mem_addr   = (state == S_FETCH) ? pc : ar;
    assign o_mem_wdata  = (op == OP_STA) ? ac :
                          (op == OP_BSA) ? {{(DWIDTH-AWIDTH){1'b0}}, pc} : dr;
    assign o_pc         = pc;
    assign o_ac         = ac;
    assign o_ir         = ir;
    assign o_e          = e;
    assign o_halted     = (state == S_IDLE) || (state == S_HALT);
    assign o_instr_done = (state == S_REG) ||
                          (state == S_OP && op != OP_ISZ) ||
                          (state == S_WR && i_mem_ack && op != OP_BSA);

endmodule

// File: tb/tb_basic_cpu_core.sv
// Bench for basic_cpu_core: SRAM model with programmable wait states and an
// instruction-level reference interpreter checked at every completed instruction.
module tb_basic_cpu_core;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [11:0] pc;
    logic [15:0] ac;
    logic [15:0] ir;
    logic        e;
    logic        halted;
    logic        instr_done;

    basic_cpu_core #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_pc(pc), .o_ac(ac),
        .o_ir(ir), .o_e(e), .o_halted(halted), .o_instr_done(instr_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wait_n  = 0;
    int ndone   = 0;

    logic [15:0] tb_mem [0:4095];
    logic [15:0] rmem   [0:4095];

    // reference architectural state
    logic [11:0] m_pc;
    logic [15:0] m_ac;
    logic [15:0] m_ir;
    logic        m_e;
    logic        m_halt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM model: evaluated 1 time unit after each rising edge
    int          wcnt = 0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [11:0] p_addr = '0;
    logic [15:0] p_wdata = '0;
    initial begin mem_ack = 1'b0; mem_rdata = '0; end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            p_req   = 1'b0;
            p_ack   = 1'b0;
        end else begin
            if (p_req && p_ack) begin
                if (p_we) tb_mem[p_addr] = p_wdata;
                wcnt = 0;
            end
            if (p_req && !p_ack)
                check("hs_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_we, p_addr, p_wdata});
            if (mem_req) begin
                if (wcnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 16'hDEAD : tb_mem[mem_addr];
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin tb_mem[i] = '0; rmem[i] = '0; end
    endtask

    task automatic poke(input int a, input logic [15:0] v);
        tb_mem[a] = v;
        rmem[a]   = v;
    endtask

    // Executes one instruction at ISA level; returns expected cycle count.
    task automatic ref_step(output int exp_lat);
        int unsigned s;
        int          hb, base, acc;
        logic [2:0]  opc;
        logic [11:0] a;
        logic [15:0] d;
        m_ir = rmem[m_pc];
        m_pc = m_pc + 12'd1;
        opc  = m_ir[14:12];
        a    = m_ir[11:0];
        base = 3;
        acc  = 1;
        if (opc != 3'd7 && m_ir[15]) begin
            a = rmem[a][11:0];
            base++; acc++;
        end
        case (opc)
            3'd0: begin m_ac = m_ac & rmem[a]; base++; acc++; end
            3'd1: begin
                s    = int'(m_ac) + int'(rmem[a]);
                m_e  = (s > 32'hFFFF);
                m_ac = 16'(s & 32'hFFFF);
                base++; acc++;
            end
            3'd2: begin m_ac = rmem[a]; base++; acc++; end
            3'd3: begin rmem[a] = m_ac; acc++; end
            3'd4: m_pc = a;
            3'd5: begin rmem[a] = {4'h0, m_pc}; m_pc = a + 12'd1; base++; acc++; end
            3'd6: begin
                d = rmem[a] + 16'd1;
                rmem[a] = d;
                if (d == 16'd0) m_pc = m_pc + 12'd1;
                base += 2; acc += 2;
            end
            default: begin
                hb = -1;
                if (!m_ir[15])
                    for (int b = 11; b >= 0; b--) if (m_ir[b] && hb < 0) hb = b;
                case (hb)
                    11: m_ac = 16'h0000;
                    10: m_e = 1'b0;
                    9:  m_ac = ~m_ac;
                    8:  m_e = ~m_e;
                    7:  begin s = int'(m_ac); m_ac = 16'((s >> 1) | (m_e ? 32'h8000 : 0)); m_e = s[0]; end
                    6:  begin s = int'(m_ac); m_ac = 16'(((s << 1) | int'(m_e)) & 32'hFFFF); m_e = (s >= 32'h8000); end
                    5:  m_ac = m_ac + 16'd1;
                    4:  if (m_ac < 16'h8000) m_pc = m_pc + 12'd1;
                    3:  if (m_ac >= 16'h8000) m_pc = m_pc + 12'd1;
                    2:  if (m_ac == 16'd0) m_pc = m_pc + 12'd1;
                    1:  if (!m_e) m_pc = m_pc + 12'd1;
                    0:  m_halt = 1'b1;
                    default: ;
                endcase
            end
        endcase
        exp_lat = base + wait_n * acc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_halted", halted, 1'b1);
        check("rst_done", instr_done, 1'b0);
        check("rst_pc", pc, 12'h000);
        check("rst_ac_e_ir", {ac, e, ir}, 33'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int wn, input int max_instr);
        int lat, ninstr, exp_lat, diffs;
        wait_n = wn;
        do_reset();
        m_pc = 12'h000; m_ac = '0; m_e = 1'b0; m_halt = 1'b0; m_ir = '0;
        ndone = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; lat = 1;
        check("run_busy", halted, 1'b0);
        ninstr = 0;
        while (1'b1) begin
            if (instr_done) begin
                ndone++;
                ref_step(exp_lat);
                check("latency", lat, exp_lat);
                @(negedge clk); lat = 1; ninstr++;
                check("pc", pc, m_pc);
                check("ac", ac, m_ac);
                check("e", e, m_e);
                check("ir", ir, m_ir);
                if (m_halt) begin check("halted", halted, 1'b1); break; end
                if (ninstr >= max_instr) break;
            end else begin
                if (lat >= 40) begin check("timeout", lat, 0); break; end
                @(negedge clk); lat++;
            end
        end
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (tb_mem[i] !== rmem[i]) diffs++;
        check("mem_image", diffs, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;

        // LDA then HLT, zero-wait
        clear_mem();
        poke(0, 16'h2005); poke(5, 16'h1234); poke(1, 16'h7001);
        run_prog(0, 10);
        check("lda_ac", ac, 16'h1234);
        check("lda_pc", pc, 12'h002);
        check("lda_halted", halted, 1'b1);
        check("lda_dones", ndone, 2);

        // restart from HALT resumes at PC; async reset mid-fetch drops req
        wait_n = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, 12'h002);
        check("restart_busy", halted, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", mem_req, 1'b0);
        check("async_pc", pc, 12'h000);
        check("async_halted", halted, 1'b1);

        for (int w = 0; w <= 3; w += 3) begin
            // ADD carry out
            clear_mem();
            poke(0, 16'h2005); poke(5, 16'hFFFF); poke(1, 16'h1006);
            poke(6, 16'h0001); poke(2, 16'h7001);
            run_prog(w, 10);
            check("add_ac", ac, 16'h0000);
            check("add_e", e, 1'b1);

            // indirect ISZ wraps to zero and skips
            clear_mem();
            poke(0, 16'hE010); poke(16'h010, 16'h0020); poke(16'h020, 16'hFFFF);
            poke(1, 16'h7001); poke(2, 16'h7001);
            run_prog(w, 10);
            check("isz_mem", tb_mem[12'h020], 16'h0000);
            check("isz_pc", pc, 12'h003);
            check("isz_dones", ndone, 2);

            // CIL through E, then NOP
            clear_mem();
            poke(0, 16'h2010); poke(16'h010, 16'h8001); poke(1, 16'h7040);
            poke(2, 16'h7000); poke(3, 16'h7001);
            run_prog(w, 10);
            check("cil_ac", ac, 16'h0002);
            check("cil_e", e, 1'b1);
            check("cil_pc", pc, 12'h004);
            check("cil_dones", ndone, 4);
        end

        // random memory images, random wait states
        for (int r = 0; r < 16; r++) begin
            logic [15:0] v;
            for (int i = 0; i < 4096; i++) begin
                v = 16'($urandom);
                tb_mem[i] = v;
                rmem[i]   = v;
            end
            run_prog(int'($urandom_range(0, 3)), 60);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
